// File: rtl/dcache_pkg.sv
// dcache_pkg: shared types, field offsets and helpers for the write-back data cache.
package dcache_pkg;
    localparam int IDX_W = 5;
    localparam int WORD_W = 3;
    localparam int TAG_LSB = 10;
    localparam int IDX_LSB = 5;
    localparam int WORD_LSB = 2;
    localparam int VALID_BIT = 23;
    localparam int DIRTY_BIT = 22;

    typedef logic [255:0] line_t;
    typedef logic [23:0] tag_t;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        MISS       = 3'd1,
        WRITEBACK  = 3'd2,
        READMISS   = 3'd3,
        READMISSOK = 3'd4
    } state_e;

    function automatic line_t merge_word(line_t l, logic [WORD_W-1:0] w, logic [31:0] d);
        line_t r;
        r = l;
        r[{w, 5'b0} +: 32] = d;
        return r;
    endfunction
endpackage

// File: rtl/dcache_sram.sv
// dcache_sram: tag array ({valid, dirty, tag}) and line data array sharing one index.
module dcache_sram
    import dcache_pkg::*;
#(
    parameter int LINES = 32
) (
    input  logic             clk_i,
    input  logic [IDX_W-1:0] idx_i,
    input  logic             tag_we_i,
    input  logic [23:0]      tag_wd_i,
    output logic [23:0]      tag_rd_o,
    input  logic             data_we_i,
    input  logic [255:0]     data_wd_i,
    output logic [255:0]     data_rd_o
);
    dcache_sram_bank #(.W(24), .AW($clog2(LINES))) dcache_tag_sram (
        .clk_i(clk_i), .addr_i(idx_i), .we_i(tag_we_i), .wd_i(tag_wd_i), .rd_o(tag_rd_o)
    );

    dcache_sram_bank #(.W(256), .AW($clog2(LINES))) dcache_data_sram (
        .clk_i(clk_i), .addr_i(idx_i), .we_i(data_we_i), .wd_i(data_wd_i), .rd_o(data_rd_o)
    );
endmodule

// File: rtl/dcache_sram_bank.sv
// dcache_sram_bank: unreset storage array, combinational read, write on rising edge.
module dcache_sram_bank #(
    parameter int W  = 24,
    parameter int AW = 5
) (
    input  logic          clk_i,
    input  logic [AW-1:0] addr_i,
    input  logic          we_i,
    input  logic [W-1:0]  wd_i,
    output logic [W-1:0]  rd_o
);
    logic [W-1:0] memory [1 << AW];

    always_ff @(posedge clk_i)
        if (we_i) memory[addr_i] <= wd_i;

    assign rd_o = memory[addr_i];
endmodule

// File: rtl/dcache_wb_ctrl.sv
// dcache_wb_ctrl: direct-mapped write-back/write-allocate cache controller.
// Define DCACHE_STATS_EN to add saturating hit/miss counters (hit_cnt_o, miss_cnt_o).
module dcache_wb_ctrl
    import dcache_pkg::*;
#(
    parameter int LINES     = 32,
    parameter int LINE_BITS = 256,
    parameter int TAG_BITS  = 22
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [31:0]          p1_addr_i,
    input  logic [31:0]          p1_data_i,
    input  logic                 p1_MemRead_i,
    input  logic                 p1_MemWrite_i,
    output logic [31:0]          p1_data_o,
    output logic                 p1_stall_o,
    output logic [31:0]          mem_addr_o,
    output logic [LINE_BITS-1:0] mem_data_o,
    output logic                 mem_enable_o,
    output logic                 mem_write_o,
    input  logic [LINE_BITS-1:0] mem_data_i,
    input  logic                 mem_ack_i
`ifdef DCACHE_STATS_EN
    ,
    output logic [15:0]          hit_cnt_o,
    output logic [15:0]          miss_cnt_o
`endif
);
    state_e state_q, state_d;
    logic [TAG_BITS-1:0] req_tag;
    logic [IDX_W-1:0] idx;
    logic [WORD_W-1:0] word;
    tag_t tag_rd, tag_wd;
    line_t line_rd, line_wd, refill_q;
    logic req, hit, idle, wr_hit, arr_we;
    logic mem_enable_q, mem_enable_d, mem_write_q, mem_write_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    line_t mem_data_q, mem_data_d;
    logic unused_addr;

    assign req_tag = p1_addr_i[31:TAG_LSB];
    assign idx = p1_addr_i[TAG_LSB-1:IDX_LSB];
    assign word = p1_addr_i[IDX_LSB-1:WORD_LSB];
    assign unused_addr = ^p1_addr_i[WORD_LSB-1:0];

    assign req = p1_MemRead_i | p1_MemWrite_i;
    assign hit = tag_rd[VALID_BIT] && tag_rd[TAG_BITS-1:0] == req_tag;
    assign idle = state_q == IDLE;
    assign wr_hit = idle && p1_MemWrite_i && hit;
    assign p1_stall_o = !idle || (req && !hit);
    assign p1_data_o = (idle && req && hit) ? line_rd[{word, 5'b0} +: 32] : '0;

    // Array writes are suppressed during reset so an aborted refill leaves the line untouched.
    assign arr_we = !rst_i && (wr_hit || state_q == READMISSOK);
    assign tag_wd = {1'b1, wr_hit, req_tag};
    assign line_wd = wr_hit ? merge_word(line_rd, word, p1_data_i) : refill_q;

    dcache_sram #(.LINES(LINES)) u_sram (
        .clk_i(clk_i), .idx_i(idx),
        .tag_we_i(arr_we), .tag_wd_i(tag_wd), .tag_rd_o(tag_rd),
        .data_we_i(arr_we), .data_wd_i(line_wd), .data_rd_o(line_rd)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:      state_d = (req && !hit) ? MISS : IDLE;
            MISS:      state_d = tag_rd[DIRTY_BIT] ? WRITEBACK : READMISS;
            WRITEBACK: state_d = mem_ack_i ? READMISS : WRITEBACK;
            READMISS:  state_d = mem_ack_i ? READMISSOK : READMISS;
            default:   state_d = IDLE;
        endcase
        // Memory request registers load from the state being entered, so they are stable from entry.
        mem_enable_d = state_d == WRITEBACK || state_d == READMISS;
        mem_write_d = state_d == WRITEBACK;
        mem_addr_d = state_d == WRITEBACK ? {tag_rd[TAG_BITS-1:0], idx, 5'b0} :
                     state_d == READMISS  ? {req_tag, idx, 5'b0} : mem_addr_q;
        mem_data_d = state_d == WRITEBACK ? line_rd : mem_data_q;
    end

    always_ff @(posedge clk_i or posedge rst_i)
        if (rst_i) begin
            state_q <= IDLE;
            mem_enable_q <= 1'b0;
            mem_write_q <= 1'b0;
            mem_addr_q <= '0;
            mem_data_q <= '0;
            refill_q <= '0;
        end else begin
            state_q <= state_d;
            mem_enable_q <= mem_enable_d;
            mem_write_q <= mem_write_d;
            mem_addr_q <= mem_addr_d;
            mem_data_q <= mem_data_d;
            refill_q <= (state_q == READMISS && mem_ack_i) ? mem_data_i : refill_q;
        end

    assign mem_enable_o = mem_enable_q;
    assign mem_write_o = mem_write_q;
    assign mem_addr_o = mem_addr_q;
    assign mem_data_o = mem_data_q;

`ifdef DCACHE_STATS_EN
    logic [15:0] hit_cnt_q, miss_cnt_q;

    always_ff @(posedge clk_i or posedge rst_i)
        if (rst_i) begin
            hit_cnt_q <= '0;
            miss_cnt_q <= '0;
        end else begin
            if (idle && req && hit && ~&hit_cnt_q) hit_cnt_q <= hit_cnt_q + 16'd1;
            if (idle && req && !hit && ~&miss_cnt_q) miss_cnt_q <= miss_cnt_q + 16'd1;
        end

    assign hit_cnt_o = hit_cnt_q;
    assign miss_cnt_o = miss_cnt_q;
`endif
endmodule

// File: tb/tb_dcache_wb_ctrl.sv
// tb_dcache_wb_ctrl: directed and randomized checks of the cache against a flat-memory model.
module tb_dcache_wb_ctrl;
    logic clk = 1'b0;
    logic rst;
    logic [31:0] p1_addr_i, p1_data_i, p1_data_o, mem_addr_o;
    logic p1_MemRead_i, p1_MemWrite_i, p1_stall_o, mem_enable_o, mem_write_o, mem_ack_i;
    logic [255:0] mem_data_o, mem_data_i;
`ifdef DCACHE_STATS_EN
    logic [15:0] hit_cnt, miss_cnt;
`endif

    dcache_wb_ctrl dut (
        .clk_i(clk), .rst_i(rst),
        .p1_addr_i(p1_addr_i), .p1_data_i(p1_data_i),
        .p1_MemRead_i(p1_MemRead_i), .p1_MemWrite_i(p1_MemWrite_i),
        .p1_data_o(p1_data_o), .p1_stall_o(p1_stall_o),
        .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o),
        .mem_enable_o(mem_enable_o), .mem_write_o(mem_write_o),
        .mem_data_i(mem_data_i), .mem_ack_i(mem_ack_i)
`ifdef DCACHE_STATS_EN
        , .hit_cnt_o(hit_cnt), .miss_cnt_o(miss_cnt)
`endif
    );

    always #5 clk = ~clk;

    logic [255:0] bmem [2048];
    logic [31:0] gold [16384];
    logic mv [32], md [32];
    logic [21:0] mt [32];
    int n_tests = 0, n_fail = 0;
    int n_wr = 0, n_rd = 0, last_lat_w = 0, last_lat_r = 0, exp_hit = 0, exp_miss = 0;
    logic [31:0] last_wr_addr, last_rd_addr;
    logic hold_ack = 1'b0;
    logic [10:0] rblk;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [255:0] gold_blk(input logic [10:0] b);
        logic [255:0] r;
        for (int w = 0; w < 8; w++) r[w*32 +: 32] = gold[{b, 3'(w)}];
        return r;
    endfunction

    // Block memory: acks after a random 1..4 cycles of request, one-cycle pulse.
    initial begin
        int cnt, lat;
        mem_ack_i = 1'b0;
        mem_data_i = '0;
        cnt = 0;
        lat = 1 + int'($urandom % 4);
        forever begin
            @(negedge clk);
            mem_ack_i = 1'b0;
            if (mem_enable_o && !hold_ack) begin
                cnt++;
                if (cnt >= lat) begin
                    mem_ack_i = 1'b1;
                    rblk = mem_addr_o[15:5];
                    if (mem_write_o) begin
                        bmem[rblk] = mem_data_o;
                        n_wr++;
                        last_wr_addr = mem_addr_o;
                        last_lat_w = cnt;
                    end else begin
                        mem_data_i = bmem[rblk];
                        n_rd++;
                        last_rd_addr = mem_addr_o;
                        last_lat_r = cnt;
                    end
                    cnt = 0;
                    lat = 1 + int'($urandom % 4);
                end
            end else cnt = 0;
        end
    end

    task automatic do_op(input logic [31:0] a, input logic rd, input logic wr, input logic [31:0] d);
        logic [4:0] ix;
        logic [21:0] t;
        logic hit, dirty;
        logic [31:0] vaddr;
        int nw0, nr0, stalls;
        ix = a[9:5];
        t = a[31:10];
        hit = mv[ix] && mt[ix] == t;
        dirty = !hit && mv[ix] && md[ix];
        vaddr = {mt[ix], ix, 5'b0};
        nw0 = n_wr;
        nr0 = n_rd;
        stalls = 0;
        p1_addr_i = a;
        p1_data_i = d;
        p1_MemRead_i = rd;
        p1_MemWrite_i = wr;
        for (int k = 0; k < 400; k++) begin
            #1;
            if (!p1_stall_o) break;
            if (stalls > 300) begin
                check("stall_timeout", p1_stall_o, 0);
                break;
            end
            stalls++;
            @(negedge clk);
        end
        check("stall_cycles", stalls, hit ? 0 : 3 + last_lat_r + (dirty ? last_lat_w : 0));
        if (rd && !wr) check("load_data", p1_data_o, gold[a[15:2]]);
        check("mem_reads", n_rd - nr0, hit ? 0 : 1);
        check("mem_writes", n_wr - nw0, dirty ? 1 : 0);
        if (!hit) check("refill_addr", last_rd_addr, {a[31:5], 5'b0});
        if (dirty) begin
            check("wb_addr", last_wr_addr, vaddr);
            check("wb_line", bmem[vaddr[15:5]], gold_blk(vaddr[15:5]));
        end
        exp_hit++;
        if (!hit) exp_miss++;
        md[ix] = hit ? (md[ix] | wr) : wr;
        mv[ix] = 1'b1;
        mt[ix] = t;
        if (wr) gold[a[15:2]] = d;
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        p1_addr_i = '0;
        p1_data_i = '0;
        p1_MemRead_i = 1'b0;
        p1_MemWrite_i = 1'b0;
        for (int i = 0; i < 32; i++) begin
            dut.u_sram.dcache_tag_sram.memory[i] = '0;
            dut.u_sram.dcache_data_sram.memory[i] = '0;
            mv[i] = 1'b0;
            md[i] = 1'b0;
            mt[i] = '0;
        end
        for (int i = 0; i < 2048; i++)
            for (int w = 0; w < 8; w++) bmem[i][w*32 +: 32] = $urandom;
        bmem[0][31:0] = 32'd5;
        for (int i = 0; i < 16384; i++) gold[i] = bmem[i >> 3][(i & 7) * 32 +: 32];

        @(negedge clk);
        check("rst_state", dut.state_q, 0);
        check("rst_enable", mem_enable_o, 0);
        check("rst_write", mem_write_o, 0);
        check("rst_addr", mem_addr_o, 0);
        check("rst_data", mem_data_o, 0);
        check("rst_stall", p1_stall_o, 0);
        check("rst_p1_data", p1_data_o, 0);
`ifdef DCACHE_STATS_EN
        check("rst_hit_cnt", hit_cnt, 0);
        check("rst_miss_cnt", miss_cnt, 0);
`endif
        rst = 1'b0;
        @(negedge clk);

        do_op(32'h0, 1'b1, 1'b0, 32'h0);
        check("tag0_after_refill", dut.u_sram.dcache_tag_sram.memory[0], 24'h800000);
        do_op(32'h4, 1'b0, 1'b1, 32'hA);
        check("line0_word1", dut.u_sram.dcache_data_sram.memory[0][63:32], 32'hA);
        check("tag0_dirty", dut.u_sram.dcache_tag_sram.memory[0][22], 1'b1);
        do_op(32'h400, 1'b1, 1'b0, 32'h0);
        check("wb_word1", bmem[0][63:32], 32'hA);
        check("tag0_after_conflict", dut.u_sram.dcache_tag_sram.memory[0], 24'h800001);
        do_op(32'h20, 1'b0, 1'b1, 32'h7);
        check("line1_word0", dut.u_sram.dcache_data_sram.memory[1][31:0], 32'h7);
        check("tag1_dirty", dut.u_sram.dcache_tag_sram.memory[1][22], 1'b1);
        do_op(32'h24, 1'b0, 1'b1, 32'h55);
        do_op(32'h24, 1'b1, 1'b0, 32'h0);
`ifdef DCACHE_STATS_EN
        check("hit_cnt_directed", hit_cnt, exp_hit);
        check("miss_cnt_directed", miss_cnt, exp_miss);
`endif

        hold_ack = 1'b1;
        p1_addr_i = 32'h40;
        p1_MemRead_i = 1'b1;
        p1_MemWrite_i = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (dut.state_q == 3'd3) break;
            @(negedge clk);
        end
        check("reach_readmiss", dut.state_q, 3);
        check("readmiss_enable", mem_enable_o, 1);
        rst = 1'b1;
        #1;
        check("abort_enable", mem_enable_o, 0);
        check("abort_state", dut.state_q, 0);
        p1_MemRead_i = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        hold_ack = 1'b0;
        check("abort_no_tag_write", dut.u_sram.dcache_tag_sram.memory[2], 0);
        exp_hit = 0;
        exp_miss = 0;
        @(negedge clk);

        for (int n = 0; n < 400; n++) begin
            logic [31:0] a;
            int op;
            a = {20'b0, 2'($urandom % 4), 5'($urandom), 3'($urandom), 2'b0};
            op = int'($urandom % 3);
            if ($urandom % 8 == 0) begin
                p1_MemRead_i = 1'b0;
                p1_MemWrite_i = 1'b0;
                @(negedge clk);
            end else do_op(a, op != 1, op != 0, $urandom);
        end
`ifdef DCACHE_STATS_EN
        check("hit_cnt_final", hit_cnt, exp_hit);
        check("miss_cnt_final", miss_cnt, exp_miss);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
